// File: rtl/gold_ring_pkg.sv
// gold_ring_pkg
//   Shared constants and types for the ring NIC.
//   - DATA_WIDTH        : packet / register data width
//   - ADDR_*            : processor register map
//   - VC_BIT, DIR_BIT, HOP_*, SRC_* : packet field positions
//   - chan_state_e      : state of a one-entry channel buffer
package gold_ring_pkg;

    localparam int DATA_WIDTH = 64;

    localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
    localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
    localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int SRC_MSB = 47;
    localparam int SRC_LSB = 32;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/gold_nic_channel_buf.sv
// gold_nic_channel_buf
//   One-entry buffer with an EMPTY/FULL state machine.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     i_load      : capture i_data; honoured only while EMPTY
//     i_data      : data to capture
//     i_unload    : release the entry; honoured only while FULL
//     o_data      : buffered data (holds its last value after unload)
//     o_state     : current state (CH_EMPTY / CH_FULL)
module gold_nic_channel_buf
    import gold_ring_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_unload,
    output logic [W-1:0] o_data,
    output chan_state_e  o_state
);

    chan_state_e  r_state;
    logic [W-1:0] r_data;

    // A load in FULL and an unload in EMPTY are ignored, so the two strobes
    // can never collide on the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                CH_EMPTY: begin
                    if (i_load) begin
                        r_data  <= i_data;
                        r_state <= CH_FULL;
                    end
                end
                CH_FULL: begin
                    if (i_unload) begin
                        r_state <= CH_EMPTY;
                    end
                end
                default: r_state <= CH_EMPTY;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_state = r_state;

endmodule

// File: rtl/gold_ring_nic.sv
// gold_ring_nic
//   Network interface between a processor core and the local PE port of a
//   ring router. One injection buffer (processor -> router) and one ejection
//   buffer (router -> processor), each a single 64-bit entry.
//   Ports:
//     clk, reset                 : clock, asynchronous active-low reset
//     addr, d_in, d_out          : processor register access
//     nicEn, nicWrEn             : access enable, 1 = write / 0 = read
//     net_so, net_ro, net_do     : injection to router (send, ready, data)
//     net_polarity               : router even/odd phase
//     net_si, net_ri, net_di     : ejection from router (send, ready, data)
//   Register map: 0 input buffer (read pops), 1 input status,
//                 2 output buffer (write only), 3 output status.
//
// Handshake: a transfer happens on a rising edge where the sender's send
// and the receiver's ready are both 1 in the cycle before that edge. The
// sender holds data stable while send is high; ready does not depend on
// send in the same cycle.
module gold_ring_nic
    import gold_ring_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_in_full;
    logic                  w_out_full;
    logic                  w_in_load;
    logic                  w_in_unload;
    logic                  w_out_load;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [DATA_WIDTH-1:0] w_out_data;
    chan_state_e           w_in_state;
    chan_state_e           w_out_state;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn &  nicWrEn;

    assign w_in_full  = (w_in_state  == CH_FULL);
    assign w_out_full = (w_out_state == CH_FULL);

    // Ejection: ready is purely the registered empty state, so a pop of the
    // input buffer frees it only from the following cycle.
    assign net_ri      = ~w_in_full;
    assign w_in_load   = net_si & ~w_in_full;
    assign w_in_unload = w_rd & (addr == ADDR_WIDTH'(ADDR_IN_BUF)) & w_in_full;

    // Injection: a packet only leaves when its VC bit matches the router's
    // current phase. A write while full (including the draining cycle) is
    // dropped because the buffer only loads from EMPTY.
    assign net_so     = w_out_full & net_ro & (w_out_data[VC_BIT] == net_polarity);
    assign net_do     = w_out_data;
    assign w_out_load = w_wr & (addr == ADDR_WIDTH'(ADDR_OUT_BUF)) & ~w_out_full;

    gold_nic_channel_buf #(.W(DATA_WIDTH)) u_in_buf (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_in_load),
        .i_data   (net_di),
        .i_unload (w_in_unload),
        .o_data   (w_in_data),
        .o_state  (w_in_state)
    );

    gold_nic_channel_buf #(.W(DATA_WIDTH)) u_out_buf (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_out_load),
        .i_data   (d_in),
        .i_unload (net_so),
        .o_data   (w_out_data),
        .o_state  (w_out_state)
    );

    always_comb begin
        d_out = '0;
        if (w_rd) begin
            case (addr)
                ADDR_WIDTH'(ADDR_IN_BUF):   d_out = w_in_data;
                ADDR_WIDTH'(ADDR_IN_STAT):  d_out = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
                ADDR_WIDTH'(ADDR_OUT_STAT): d_out = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
                default:                    d_out = '0;
            endcase
        end
    end

endmodule

// File: doc/gold_ring_nic.md
Name: gold_ring_nic

Overview:
- Network interface controller between a processor core and the local PE port of one ring router.
- Exposes a 4-word memory-mapped register interface to the processor.
- Holds one 64-bit injection (output-channel) buffer and one 64-bit ejection (input-channel) buffer.
- Moves packets between those buffers and the router local port using send/ready handshakes.

Parameters:
- DATA_WIDTH, 64, packet and register data width.
- ADDR_WIDTH, 2, processor register address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_WIDTH  register select: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status.
- d_in  input  DATA_WIDTH  processor write data.
- d_out  output  DATA_WIDTH  processor read data.
- nicEn  input  1  processor access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_so  output  1  send to router local input (router pesi).
- net_ro  input  1  router ready for injection (router peri).
- net_do  output  DATA_WIDTH  injected packet (router pedi).
- net_polarity  input  1  router polarity (even/odd cycle).
- net_si  input  1  router sending to NIC (router peso).
- net_ri  output  1  NIC ready to accept (router pero).
- net_di  input  DATA_WIDTH  ejected packet (router pedo).

Behaviour:
- Reset (reset low, asynchronous): both buffers cleared to 0 and both full flags cleared. Resulting outputs: net_so = 0, net_do = 0, net_ri = 1, d_out = 0.
- State: per channel, a 1-bit full flag plus a data register. Each channel is effectively an EMPTY/FULL FSM.
- Ejection (router to NIC):
  - net_ri = ~in_full, combinational from the register.
  - If net_si && net_ri at a clock edge: capture net_di, set in_full.
  - net_si while full is ignored; the router must not send then.
- Injection (NIC to router):
  - net_so = out_full && net_ro && (out_buf[63] == net_polarity); net_do = out_buf.
  - When net_so = 1, the transfer completes at that edge and out_full clears.
  - A packet whose VC bit (63) mismatches net_polarity waits, which gives at least one cycle of latency per polarity phase.
- Processor writes (nicEn && nicWrEn at the edge):
  - addr 2 while out_full = 0: load d_in, set out_full.
  - addr 2 while out_full = 1: dropped, with no state change. This includes the cycle in which the buffer is draining.
  - Writes to addr 0, 1, 3: ignored.
- Processor reads (combinational d_out when nicEn && ~nicWrEn, else 0):
  - addr 0: returns in_buf. If in_full, clears in_full at the edge.
  - addr 1: returns {63'b0, in_full}.
  - addr 2: returns 0.
  - addr 3: returns {63'b0, out_full}.
- Latency:
  - Processor write to net_so is at least 1 cycle.
  - Router capture to processor-visible status is 1 cycle.
- Simultaneous events:
  - Read of input buffer while full: net_ri stays 0 that cycle. Next arrival is accepted from the following cycle, so there is no same-cycle refill.
  - Injection and ejection are independent and may complete in the same cycle.
- Reset mid-transfer: buffered packets are discarded. Outputs return to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package gold_ring_pkg:
  - DATA_WIDTH constant.
  - Register address constants (ADDR_IN_BUF, ADDR_IN_STAT, ADDR_OUT_BUF, ADDR_OUT_STAT).
  - Packet field positions: VC_BIT = 63, DIR_BIT = 62, HOP field 55:48, SRC field 47:32.
- One natural sub-module, gold_nic_channel_buf: a 1-entry buffer with full flag and load/unload strobes. Instantiated twice, once per channel.

Test Plan:
- Reset check: assert reset = 0 mid-simulation with both buffers full. Required: net_so = 0, net_ri = 1, d_out = 0 immediately; status reads return 0 after reset is released.
- Injection: write 64'h8000_0000_0000_00AA to addr 2 with net_ro = 1. Required: net_so pulses for exactly one cycle when net_polarity = 1, with net_do = 64'h8000_0000_0000_00AA. The addr 3 read returns 1 before the pulse and 0 after.
- Polarity and backpressure: load 64'h0000_0000_0000_0055 (VC bit 0) while net_polarity = 1 and net_ro toggles. Required: no net_so until net_polarity = 0 and net_ro = 1 together; a second write to addr 2 while full is dropped.
- Ejection: drive net_si = 1 with net_di = 64'h1234_5678_9ABC_DEF0. Required: net_ri drops the next cycle; the addr 1 read returns 1; the addr 0 read returns 64'h1234_5678_9ABC_DEF0; net_ri returns to 1 one cycle after that read.
- Concurrency: an injection and an ejection complete in the same cycle while the processor reads addr 1. Required: both buffers update correctly and the data is not corrupted.
